// File: rtl/wide_word_serializer.sv
// rtl/wide_word_serializer.sv - splits a WIDTH-bit word into NBEATS BEAT-bit beats, LSB beat first.
// Optional feature: define WWS_PARITY_EN to add the out_par even-parity output.
module wide_word_serializer #(
  parameter int WIDTH = 1050,
  parameter int BEAT  = 64,
  parameter int NBEATS = (WIDTH + BEAT - 1) / BEAT,
  parameter int IDXW   = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BEAT-1:0]  out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last
`ifdef WWS_PARITY_EN
  ,output logic            out_par
`endif
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDXW-1:0]           r_idx;
  logic [IDXW-1:0]           w_idx_nxt;
  logic [BEAT-1:0]           r_hold [NBEATS];
  logic [NBEATS*BEAT-1:0]    w_padded;
  logic                      w_hs;
  logic                      w_last;
  logic                      w_accept;

  // Zero-extend so bits of the final beat above WIDTH-1 read as 0.
  always_comb begin
    w_padded = '0;
    w_padded[WIDTH-1:0] = in_data;
  end

  assign w_last   = (r_idx == LAST_IDX);
  assign w_hs     = (r_state == SEND) && out_ready;
  assign in_ready = (r_state == IDLE) || (w_hs && w_last);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_accept) begin
      w_state_nxt = SEND;
      w_idx_nxt   = '0;
    end else if (w_hs) begin
      if (w_last) begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end else begin
        w_idx_nxt = r_idx + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBEATS; i++) r_hold[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NBEATS; i++) r_hold[i] <= w_padded[i*BEAT +: BEAT];
    end
  end

  // All beat outputs are forced to 0 whenever no beat is being presented.
  assign out_valid = (r_state == SEND);
  assign out_data  = out_valid ? r_hold[r_idx] : '0;
  assign out_idx   = out_valid ? r_idx : '0;
  assign out_last  = out_valid && w_last;

`ifdef WWS_PARITY_EN
  assign out_par = ^out_data;
`endif

endmodule
